// File: rtl/mac_feeder_pkg.sv
// Shared types and default sizing for the MAC operand feeder.
package mac_feeder_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Width of a pair count able to hold 0..depth inclusive.
    function automatic int unsigned len_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index into the operand store; never below one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/operand_regfile.sv
// Operand pair store: one synchronous write port, one combinational read port,
// synchronous clear on reset.
module operand_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic signed [DATA_W-1:0] rd_a,
    output logic signed [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    // Out-of-range write addresses are discarded when DEPTH is not a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Sequencer in front of a MAC lane: clears the accumulator, streams operand
// pairs, counts returned products and captures the final dot product.
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned ACC_W  = ACC_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned LEN_W  = len_w(DEPTH),
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic                     start,
    input  logic        [LEN_W-1:0]  len,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  result,
    output logic                     mac_clear,
    output logic signed [DATA_W-1:0] mac_a,
    output logic signed [DATA_W-1:0] mac_b,
    output logic                     mac_valid,
    input  logic signed [ACC_W-1:0]  mac_f,
    input  logic                     mac_valid_out
);

    feeder_state_t            state;
    logic        [LEN_W-1:0]  len_q;
    logic        [LEN_W-1:0]  idx;
    logic        [LEN_W-1:0]  vcnt;
    logic        [LEN_W-1:0]  len_clamped;
    logic signed [DATA_W-1:0] rd_a;
    logic signed [DATA_W-1:0] rd_b;

    assign len_clamped = (32'(len) > DEPTH) ? LEN_W'(DEPTH) : len;

    // Writes are only accepted while idle so a run sees a stable operand set.
    operand_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .rd_addr (ADDR_W'(idx)),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // FSM and registered outputs; pulse-type outputs default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            idx       <= '0;
            vcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_valid <= 1'b0;
            mac_clear <= 1'b1;
        end else begin
            done      <= 1'b0;
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        len_q     <= len_clamped;
                        idx       <= '0;
                        vcnt      <= '0;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (len_q == '0) begin
                        state  <= DONE;
                        result <= '0;
                        done   <= 1'b1;
                    end else begin
                        state     <= STREAM;
                        mac_valid <= 1'b1;
                        mac_a     <= rd_a;
                        mac_b     <= rd_b;
                        idx       <= idx + LEN_W'(1);
                    end
                end
                STREAM: begin
                    // Early products can return while later pairs are still issuing.
                    if (mac_valid_out) begin
                        vcnt <= vcnt + LEN_W'(1);
                    end
                    if (idx == len_q) begin
                        state <= DRAIN;
                    end else begin
                        mac_valid <= 1'b1;
                        mac_a     <= rd_a;
                        mac_b     <= rd_b;
                        idx       <= idx + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (mac_valid_out) begin
                        if (vcnt == len_q - LEN_W'(1)) begin
                            result <= mac_f;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            vcnt <= vcnt + LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a two-stage MAC model and a
// result scoreboard.
module tb_mac_operand_feeder;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ADDR_W = 4;
    localparam int          TMO    = 100;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_en;
    logic        [ADDR_W-1:0] wr_addr;
    logic signed [DATA_W-1:0] wr_a;
    logic signed [DATA_W-1:0] wr_b;
    logic                     start;
    logic        [LEN_W-1:0]  len;
    logic                     busy;
    logic                     done;
    logic signed [ACC_W-1:0]  result;
    logic                     mac_clear;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic                     mac_valid;
    logic signed [ACC_W-1:0]  mac_f;
    logic                     mac_valid_out;

    int checks = 0;
    int errors = 0;
    logic signed [ACC_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    mac_operand_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_a          (wr_a),
        .wr_b          (wr_b),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .mac_clear     (mac_clear),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid     (mac_valid),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out)
    );

    // MAC model: product registered, then accumulated; valid_out two cycles after valid_in.
    logic signed [ACC_W-1:0] prod;
    logic                    v1;
    always @(posedge clk) begin
        if (mac_clear) begin
            prod          <= '0;
            v1            <= 1'b0;
            mac_f         <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            prod          <= ACC_W'(mac_a) * ACC_W'(mac_b);
            v1            <= mac_valid;
            mac_valid_out <= v1;
            if (v1) mac_f <= mac_f + prod;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_pair(input int addr, input int a, input int b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_a    = DATA_W'(a);
        wr_b    = DATA_W'(b);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_mac_a"},     32'(mac_a),     32'd0);
        check({tag, "_mac_b"},     32'(mac_b),     32'd0);
        check({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
        check({tag, "_mac_clear"}, 32'(mac_clear), 32'd1);
    endtask

    // One run; cycle numbering starts at 0 for the cycle in which start is sampled.
    task automatic run(input string tag, input int n, input int exp_res,
                       input int pairs, input bit inject);
        int cyc;
        int vcount;
        int first;
        int last;
        int exp_done;
        logic signed [ACC_W-1:0] exp_r;
        exp_q.push_back(ACC_W'(exp_res));
        exp_done = (pairs == 0) ? 2 : pairs + 4;
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_c1_clear"}, 32'(mac_clear), 32'd1);
        check({tag, "_c1_busy"},  32'(busy),      32'd1);
        vcount = 0;
        first  = -1;
        last   = -1;
        while (done !== 1'b1 && cyc < TMO) begin
            if (mac_valid === 1'b1) begin
                vcount++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (inject && cyc == 4) begin
                start   = 1'b1;
                len     = LEN_W'(1);
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(DEPTH - 1);
                wr_a    = '0;
                wr_b    = '0;
            end
            if (inject && cyc == 5) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        exp_r = exp_q.pop_front();
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_pairs"}, 32'(vcount), 32'(pairs));
        if (pairs > 0) begin
            check({tag, "_first_valid"}, 32'(first), 32'd2);
            check({tag, "_last_valid"},  32'(last),  32'(pairs + 1));
        end
        @(negedge clk);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen_done;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_a    = '0;
        wr_b    = '0;
        start   = 1'b0;
        len     = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("rst_clear_drop", 32'(mac_clear), 32'd0);

        write_pair(0, 1, 4);
        write_pair(1, 2, 5);
        write_pair(2, 3, 6);
        run("basic", 3, 32, 3, 1'b0);

        write_pair(0, -128, -128);
        write_pair(1, -1, 127);
        run("signed", 2, 16257, 2, 1'b0);

        for (int i = 0; i < int'(DEPTH); i++) write_pair(i, 127, 127);
        run("wrap", 16, -4080, 16, 1'b0);
        run("len0", 0, 0, 0, 1'b0);
        run("clamp", 20, -4080, 16, 1'b0);
        run("ignore", 16, -4080, 16, 1'b1);
        run("stable", 16, -4080, 16, 1'b0);

        write_pair(0, 2, 3);
        run("second", 1, 6, 1, 1'b0);

        // Abort a len=8 run in cycle 3.
        for (int i = 0; i < 8; i++) write_pair(i, i + 1, 3);
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("abort");
        seen_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run("cleared", 4, 0, 4, 1'b0);
        write_pair(0, 2, 3);
        run("after_abort", 1, 6, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
